// File: rtl/vx_warp_ibuffer.sv
// Single-warp in-order instruction FIFO with a same-cycle flush.
// Latency: a push is visible at the head one cycle later; there is no bypass.
// Backpressure: the parent gates pushes with full; pops must be gated with !empty.
module vx_ibuf_fifo #(
    parameter int DEPTH = 2,
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [DATAW-1:0] push_dat,
    input  logic             pop_vld,
    input  logic             flush_vld,
    output logic [DATAW-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [CNTW-1:0]  count;

    // Payload storage carries no reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Flush wins over any same-cycle pop; pushes are already refused upstream.
    always_ff @(posedge clk) begin
        if (reset || flush_vld) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (push_vld && !pop_vld) begin
                count <= count + CNTW'(1);
            end else if (pop_vld && !push_vld) begin
                count <= count - CNTW'(1);
            end
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pop_vld && empty));
            assert (!(push_vld && full));
        end
    end
endmodule

// Per-warp instruction buffer: one decoded instruction in per cycle, one head per warp out.
// Latency: one cycle from accepted push to out_valid of that warp.
// Backpressure: in_ready drops when the target warp is full or being flushed; heads hold while out_ready is low.
module vx_warp_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 2,
    parameter int DATAW     = 64,
    parameter int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDW-1:0]            in_wid,
    input  logic [DATAW-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       flush_valid,
    input  logic [WIDW-1:0]            flush_wid,
    output logic [NUM_WARPS-1:0]       out_valid,
    output logic [NUM_WARPS*DATAW-1:0] out_data,
    input  logic [NUM_WARPS-1:0]       out_ready,
    output logic [NUM_WARPS-1:0]       full,
    output logic [NUM_WARPS-1:0]       empty
);
    logic [NUM_WARPS-1:0] push_vld;
    logic [NUM_WARPS-1:0] pop_vld;
    logic [NUM_WARPS-1:0] flush_vld;
    logic                 full_sel;

    // Decode by compare so a warp ID beyond NUM_WARPS never indexes out of range.
    always_comb begin
        full_sel = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (in_wid == WIDW'(w)) begin
                full_sel = full[w];
            end
        end
    end

    assign in_ready  = !full_sel && !(flush_valid && (flush_wid == in_wid));
    assign out_valid = ~empty;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign push_vld[w]  = in_valid && in_ready && (in_wid == WIDW'(w));
        assign pop_vld[w]   = out_valid[w] && out_ready[w];
        assign flush_vld[w] = flush_valid && (flush_wid == WIDW'(w));

        vx_ibuf_fifo #(
            .DEPTH (DEPTH),
            .DATAW (DATAW)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push_vld  (push_vld[w]),
            .push_dat  (in_data),
            .pop_vld   (pop_vld[w]),
            .flush_vld (flush_vld[w]),
            .head_dat  (out_data[w*DATAW +: DATAW]),
            .full      (full[w]),
            .empty     (empty[w])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!in_valid || (32'(in_wid) < NUM_WARPS));
            assert (!flush_valid || (32'(flush_wid) < NUM_WARPS));
        end
    end
endmodule
